// File: rtl/mvm_accumulator.sv
// mvm_accumulator
//   Accumulates NTILE column-tile partial sums per lane, adds a per-lane bias,
//   then requantizes each lane from Q(WIA).(WFO) to Q(WIR).(WFR) with
//   saturation, and presents the result through a valid/ready handshake.
//
// Configuration macro:
//   MVM_ACC_ROUND_EN  defined   -> round-half-up before the requantize shift
//                     undefined -> truncation (shift rounds toward -inf)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   in_valid   in_data carries a tile partial sum
//   in_ready   block accepts a beat this cycle (registered, high only in ACC)
//   in_data    VP lanes of Q(WIO).(WFO), lane j at [(j+1)*LI-1 : j*LI]
//   bias       VP lanes of Q(WIB).(WFB), must be stable while in BIAS
//   out_valid  out_data/sat_flag are valid
//   out_ready  consumer accepts out_data
//   out_data   VP lanes of Q(WIR).(WFR)
//   sat_flag   per-lane: lane was clamped in the current out_data
//   state_dbg  current FSM state (ACC=0, BIAS=1, RND=2, HOLD=3)
//
// Handshake: a transfer happens at a rising edge where valid and ready are
// both high. in_ready and out_valid are flops, so neither depends
// combinationally on any input.
module mvm_accumulator #(
   parameter int VP    = 3,
   parameter int WIO   = 10,
   parameter int WFO   = 22,
   parameter int WIB   = 4,
   parameter int WFB   = 12,
   parameter int WIR   = 4,
   parameter int WFR   = 12,
   parameter int NTILE = 4,
   parameter int WIA   = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [VP*(WIO+WFO)-1:0]   in_data,
   input  logic [VP*(WIB+WFB)-1:0]   bias,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [VP*(WIR+WFR)-1:0]   out_data,
   output logic [VP-1:0]             sat_flag,
   output logic [1:0]                state_dbg
);

   localparam int LI   = WIO + WFO;   // input lane width
   localparam int LB   = WIB + WFB;   // bias lane width
   localparam int WR   = WIR + WFR;   // result lane width
   localparam int WA   = WIA + WFO;   // accumulator width
   localparam int SH_B = WFO - WFB;   // bias alignment shift
   localparam int SH_R = WFO - WFR;   // requantize shift
   localparam int CW   = (NTILE > 1) ? $clog2(NTILE) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(NTILE - 1);

`ifdef MVM_ACC_ROUND_EN
   localparam logic signed [WA-1:0] RND_C = WA'(1) << (SH_R - 1);
`else
   localparam logic signed [WA-1:0] RND_C = '0;
`endif

   // Result range expressed at accumulator width; min is the bitwise
   // complement of max in two's complement.
   localparam logic signed [WA-1:0] SAT_MAX = (WA'(1) << (WR - 1)) - WA'(1);
   localparam logic signed [WA-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      ST_ACC  = 2'd0,
      ST_BIAS = 2'd1,
      ST_RND  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic signed [WA-1:0]   acc_q [VP];
   logic signed [WA-1:0]   acc_d [VP];
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [VP*WR-1:0]       out_data_q, out_data_d;
   logic [VP-1:0]          sat_q, sat_d;

   logic signed [WA-1:0]   in_ext   [VP];
   logic signed [WA-1:0]   bias_ext [VP];
   logic [WR-1:0]          lane_res [VP];
   logic [VP-1:0]          lane_sat;

   // Per-lane datapath: operand alignment and requantization.
   for (genvar j = 0; j < VP; j++) begin : g_lane
      logic signed [LI-1:0] in_lane;
      logic signed [LB-1:0] b_lane;
      logic signed [WA-1:0] rsum;
      logic signed [WA-1:0] rshift;
      logic                 over_hi;
      logic                 over_lo;

      assign in_lane     = in_data[j*LI +: LI];
      assign b_lane      = bias[j*LB +: LB];
      assign in_ext[j]   = WA'(in_lane);
      assign bias_ext[j] = WA'(b_lane) <<< SH_B;

      assign rsum    = acc_q[j] + RND_C;
      assign rshift  = rsum >>> SH_R;
      assign over_hi = (rshift > SAT_MAX);
      assign over_lo = (rshift < SAT_MIN);

      assign lane_sat[j] = over_hi | over_lo;
      assign lane_res[j] = over_hi ? WR'(SAT_MAX) :
                           over_lo ? WR'(SAT_MIN) : rshift[WR-1:0];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sat_d       = sat_q;

      case (state_q)
         ST_ACC: begin
            if (in_valid) begin
               for (int j = 0; j < VP; j++) acc_d[j] = acc_q[j] + in_ext[j];
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_BIAS;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_BIAS: begin
            for (int j = 0; j < VP; j++) acc_d[j] = acc_q[j] + bias_ext[j];
            state_d = ST_RND;
         end
         ST_RND: begin
            for (int j = 0; j < VP; j++) out_data_d[j*WR +: WR] = lane_res[j];
            sat_d       = lane_sat;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               for (int j = 0; j < VP; j++) acc_d[j] = '0;
               state_d = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase

      // Registered ready: high exactly when the next state accepts beats.
      in_ready_d = (state_d == ST_ACC);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_ACC;
         cnt_q       <= '0;
         for (int j = 0; j < VP; j++) acc_q[j] <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_q       <= sat_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_flag  = sat_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mvm_accumulator.sv
// tb_mvm_accumulator
//   Directed testbench for mvm_accumulator at default parameters. Expected
//   lane values are hand-computed from the Q10.22 / Q4.12 arithmetic.
module tb_mvm_accumulator;

   localparam int VP = 3;
   localparam int LI = 32;
   localparam int LB = 16;
   localparam int LR = 16;

`ifdef MVM_ACC_ROUND_EN
   localparam bit RND_EN = 1'b1;
`else
   localparam bit RND_EN = 1'b0;
`endif

   localparam logic [1:0] S_ACC  = 2'd0;
   localparam logic [1:0] S_BIAS = 2'd1;
   localparam logic [1:0] S_RND  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [31:0] ONE_I = 32'h0040_0000;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [VP*LI-1:0] in_data;
   logic [VP*LB-1:0] bias;
   logic             out_valid;
   logic             out_ready;
   logic [VP*LR-1:0] out_data;
   logic [VP-1:0]    sat_flag;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   mvm_accumulator dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_flag  (sat_flag),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int                checks = 0;
   int                errors = 0;
   logic [VP*LR-1:0]  exp_q[$];
   logic [VP-1:0]     exp_sat_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [VP*LI-1:0] pk_in(input logic [31:0] l0, input logic [31:0] l1,
                                               input logic [31:0] l2);
      return {l2, l1, l0};
   endfunction

   function automatic logic [VP*LB-1:0] pk16(input logic [15:0] l0, input logic [15:0] l1,
                                              input logic [15:0] l2);
      return {l2, l1, l0};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [VP*LI-1:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check("beat_ready_timeout", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Sends four beats; optional 1-3 cycle bubbles. Checks the
   // last-beat -> out_valid latency of two edges.
   task automatic send_block(input string tag,
                             input logic [VP*LI-1:0] d0, input logic [VP*LI-1:0] d1,
                             input logic [VP*LI-1:0] d2, input logic [VP*LI-1:0] d3,
                             input bit gaps);
      logic [VP*LI-1:0] d;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       d = d0;
            1:       d = d1;
            2:       d = d2;
            default: d = d3;
         endcase
         if (gaps && i > 0) repeat ($urandom_range(1, 3)) tick();
         send_beat(d);
      end
      check({tag, "_st_bias"}, 64'(state_dbg), 64'(S_BIAS));
      check({tag, "_rdy_bias"}, 64'(in_ready), 64'd0);
      check({tag, "_ov_t1"}, 64'(out_valid), 64'd0);
      tick();
      check({tag, "_st_rnd"}, 64'(state_dbg), 64'(S_RND));
      tick();
      check({tag, "_ov_t2"}, 64'(out_valid), 64'd1);
   endtask

   task automatic collect(input string tag);
      logic [VP*LR-1:0] ed;
      logic [VP-1:0]    es;
      int               n;
      ed = exp_q.pop_front();
      es = exp_sat_q.pop_front();
      n  = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(ed));
      check({tag, "_sat"}, 64'(sat_flag), 64'(es));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
      check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      bias      = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_sat", 64'(sat_flag), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(S_ACC));
      reset = 1'b1;
      tick();

      // Basic accumulate: 4 x 1.0 + 0.5 = 4.5 -> 0x4800
      bias = pk16(16'h0800, 16'h0000, 16'h0000);
      exp_q.push_back(pk16(16'h4800, 16'h0000, 16'h0000));
      exp_sat_q.push_back(3'b000);
      send_block("basic", pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0),
                 pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0), 1'b0);
      collect("basic");

      // Saturation: lane1 4 x 3.0 = 12 -> 0x7FFF, lane2 4 x -3.0 -> 0x8000
      bias = '0;
      exp_q.push_back(pk16(16'h0000, 16'h7FFF, 16'h8000));
      exp_sat_q.push_back(3'b110);
      for (int i = 0; i < 1; i++) begin
         logic [VP*LI-1:0] sd;
         sd = pk_in(32'h0, 32'h00C0_0000, 32'hFF40_0000);
         send_block("sat", sd, sd, sd, sd, 1'b0);
      end
      collect("sat");

      // Rounding: lane0 +2^-13, lane1 -2^-13; lane2 -1.0 with bias +1.5 -> 0.5
      bias = pk16(16'h0000, 16'h0000, 16'h1800);
      exp_q.push_back(pk16(RND_EN ? 16'h0001 : 16'h0000,
                           RND_EN ? 16'h0000 : 16'hFFFF,
                           16'h0800));
      exp_sat_q.push_back(3'b000);
      send_block("rnd", pk_in(32'h0000_0200, 32'hFFFF_FE00, 32'hFFC0_0000),
                 '0, '0, '0, 1'b0);
      collect("rnd");

      // Backpressure: hold out_ready low 5 cycles while offering beats
      bias = pk16(16'h0800, 16'h0000, 16'h0000);
      exp_q.push_back(pk16(16'h4800, 16'h0000, 16'h0000));
      exp_sat_q.push_back(3'b000);
      send_block("bp", pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0),
                 pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0), 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = pk_in(ONE_I, ONE_I, ONE_I);
         tick();
         check("bp_hold_data", 64'(out_data), 64'(pk16(16'h4800, 16'h0000, 16'h0000)));
         check("bp_hold_rdy", 64'(in_ready), 64'd0);
         check("bp_hold_state", 64'(state_dbg), 64'(S_HOLD));
      end
      in_valid = 1'b0;
      in_data  = '0;
      collect("bp");

      // Next block after backpressure excludes the ignored beats: 4.0 -> 0x4000
      bias = '0;
      exp_q.push_back(pk16(16'h4000, 16'h0000, 16'h0000));
      exp_sat_q.push_back(3'b000);
      send_block("bp_next", pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0),
                 pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0), 1'b0);
      collect("bp_next");

      // Bubbles between beats give the same 0x4800 result
      bias = pk16(16'h0800, 16'h0000, 16'h0000);
      exp_q.push_back(pk16(16'h4800, 16'h0000, 16'h0000));
      exp_sat_q.push_back(3'b000);
      send_block("bub", pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0),
                 pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0), 1'b1);
      collect("bub");

      // Mid-operation reset after 2 beats; beat offered during reset is ignored
      send_beat(pk_in(32'h00C0_0000, ONE_I, 0));
      send_beat(pk_in(32'h00C0_0000, ONE_I, 0));
      reset    = 1'b0;
      in_valid = 1'b1;
      in_data  = pk_in(ONE_I, ONE_I, ONE_I);
      tick();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      check("mrst_state", 64'(state_dbg), 64'(S_ACC));
      check("mrst_rdy", 64'(in_ready), 64'd1);
      check("mrst_ov", 64'(out_valid), 64'd0);
      check("mrst_data", 64'(out_data), 64'd0);
      check("mrst_sat", 64'(sat_flag), 64'd0);
      bias = '0;
      exp_q.push_back(pk16(16'h4000, 16'h0000, 16'h0000));
      exp_sat_q.push_back(3'b000);
      send_block("mrst", pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0),
                 pk_in(ONE_I, 0, 0), pk_in(ONE_I, 0, 0), 1'b0);
      collect("mrst");

      // ---------------- report ----------------
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
